// File: rtl/fetch_pkg.sv
// Shared types and width defaults for the picoMIPS instruction-fetch sequencer.
// Widths follow the program-ROM constants; they fall back to 8/12 when not defined elsewhere.
`ifndef PROG_MEM_ADDR_WIDTH
`define PROG_MEM_ADDR_WIDTH 8
`endif
`ifndef PROG_MEM_WIDTH
`define PROG_MEM_WIDTH 12
`endif

package fetch_pkg;

  localparam int PROG_ADDR_WIDTH = `PROG_MEM_ADDR_WIDTH;
  localparam int PROG_DATA_WIDTH = `PROG_MEM_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ret_stack.sv
// Circular return-address LIFO: a push when full overwrites the oldest entry, and a pop when empty
// does nothing else; both set the sticky err, which is cleared by reset or clear.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic             err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] entry_reg [DEPTH];
  logic [PW-1:0]    wp_reg;
  logic [CW-1:0]    count_reg;
  logic             err_reg;
  logic [PW-1:0]    wp_inc;
  logic [PW-1:0]    wp_dec;

  // wp always points at the next free slot, which is also the oldest entry once full
  assign wp_inc = (wp_reg == LAST) ? '0 : wp_reg + PW'(1);
  assign wp_dec = (wp_reg == '0) ? LAST : wp_reg - PW'(1);

  assign top   = entry_reg[wp_dec];
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign err   = err_reg;

  always_ff @(posedge clock) begin
    if (push && !clear) entry_reg[wp_reg] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_reg    <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (clear) begin
      wp_reg    <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (push) begin
      wp_reg <= wp_inc;
      if (full) err_reg <= 1'b1;
      else      count_reg <= count_reg + CW'(1);
    end else if (pop) begin
      if (empty) begin
        err_reg <= 1'b1;
      end else begin
        wp_reg    <= wp_dec;
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the picoMIPS program ROM (1-cycle registered-address ROM).
// Optional return stack (call/ret/stack_err) is enabled by defining RET_STACK_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH   = PROG_ADDR_WIDTH,
  parameter int DATA_WIDTH   = PROG_DATA_WIDTH,
  parameter int RESET_VECTOR = 0
`ifdef RET_STACK_EN
  ,
  parameter int STACK_DEPTH  = 4
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
`ifdef RET_STACK_EN
  input  logic                  call,
  input  logic                  ret,
  output logic                  stack_err,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_clr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  running
);
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(RESET_VECTOR);

  fetch_state_t          state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] instr_pc_reg, instr_pc_next;
  logic                  valid_reg, valid_next;
  logic                  fetch;
  logic [ADDR_WIDTH-1:0] fetch_addr;

`ifdef RET_STACK_EN
  logic                  stack_push;
  logic                  stack_pop;
  logic                  stack_clear;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  stack_full;
  logic                  stack_empty;

  assign stack_clear = start && (state_reg != RUN);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ret_stack (
    .clock     (clock),
    .reset     (reset),
    .clear     (stack_clear),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (instr_pc_reg + ADDR_WIDTH'(1)),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .err       (stack_err)
  );
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      pc_reg       <= START_ADDR;
      instr_pc_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    fetch         = 1'b0;
    fetch_addr    = pc_reg;
`ifdef RET_STACK_EN
    stack_push    = 1'b0;
    stack_pop     = 1'b0;
`endif
    case (state_reg)
      IDLE, HALTED: begin
        if (start) begin
          state_next = RUN;
          fetch      = 1'b1;
          fetch_addr = START_ADDR;
        end
      end
      RUN: begin
        // a stalled cycle leaves everything held and the ROM unclocked
        if (!stall) begin
          if (halt && valid_reg) begin
            state_next = HALTED;
            valid_next = 1'b0;
          end
`ifdef RET_STACK_EN
          else if (ret && valid_reg) begin
            stack_pop  = 1'b1;
            fetch      = 1'b1;
            fetch_addr = stack_empty ? pc_reg : stack_top;
          end else if (call && valid_reg) begin
            stack_push = 1'b1;
            fetch      = 1'b1;
            fetch_addr = branch_target;
          end
`endif
          else if (branch_taken && valid_reg) begin
            fetch      = 1'b1;
            fetch_addr = branch_target;
          end else begin
            fetch      = 1'b1;
            fetch_addr = pc_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (fetch) begin
      instr_pc_next = fetch_addr;
      pc_next       = fetch_addr + ADDR_WIDTH'(1);
      valid_next    = 1'b1;
    end
  end

  assign mem_addr    = fetch_addr;
  assign mem_en      = fetch;
  assign mem_clr     = ~reset;
  assign instr       = valid_reg ? mem_data : '0;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;
  assign running     = (state_reg == RUN);

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the picoMIPS program ROM, a synchronous read ROM with a registered address, a clock enable and an unregistered output.
- Owns the program counter and drives the ROM address, clock enable and clear.
- Presents each fetched word with a valid flag to decode/execute.
- Accepts stall, branch and halt from execute with zero-bubble branch redirection.

Parameters:
- ADDR_WIDTH, 8, ROM address width; equals `PROG_MEM_ADDR_WIDTH.
- DATA_WIDTH, 12, instruction width; equals `PROG_MEM_WIDTH.
- RESET_VECTOR, 0, first address fetched after start.
- STACK_DEPTH, 4, return-stack entries; only used with RET_STACK_EN.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begin fetching at RESET_VECTOR, from IDLE or HALTED.
- stall  in  1  hold the current instruction; ROM not clocked.
- branch_taken  in  1  redirect to branch_target; sampled only when instr_valid && !stall.
- branch_target  in  ADDR_WIDTH  absolute target address.
- halt  in  1  stop fetching after the current instruction; sampled only when instr_valid && !stall.
- mem_addr  out  ADDR_WIDTH  to ROM address; combinational.
- mem_en  out  1  to ROM clock enable; combinational.
- mem_clr  out  1  to ROM aclr; equals ~reset (active-high).
- mem_data  in  DATA_WIDTH  from ROM output.
- instr  out  DATA_WIDTH  equals mem_data, forced to 0 when !instr_valid.
- instr_pc  out  ADDR_WIDTH  address of instr.
- instr_valid  out  1  instr is a live instruction.
- running  out  1  state == RUN.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; pc=RESET_VECTOR; instr_pc=0; instr_valid=0.
  - mem_en=0; mem_clr=1.
  - Takes effect immediately, including mid-fetch; the in-flight fetch is discarded.
- ROM timing: address/enable presented in cycle n are latched at the n→n+1 edge; data is valid throughout n+1 while mem_en stays low. Latency is 1 cycle.
- States: IDLE, RUN, HALTED.
- IDLE / HALTED:
  - mem_en=0 and instr_valid=0 unless start=1.
  - start=1: mem_addr=RESET_VECTOR, mem_en=1. At the edge: state←RUN, instr_pc←RESET_VECTOR, instr_valid←1, pc←RESET_VECTOR+1.
- RUN, next-address priority (first match wins):
  1. stall=1: mem_en=0; pc, instr_pc, instr_valid held; branch_taken/halt ignored; execute holds them until stall drops.
  2. halt && instr_valid: mem_en=0. At the edge: state←HALTED, instr_valid←0. Halt beats branch.
  3. branch_taken && instr_valid: mem_addr=branch_target, mem_en=1. At the edge: instr_pc←branch_target, pc←branch_target+1, instr_valid←1. No bubble.
  4. Otherwise: mem_addr=pc, mem_en=1. At the edge: instr_pc←pc, pc←pc+1, instr_valid←1.
- Arithmetic: pc+1 is modulo 2^ADDR_WIDTH; address max wraps to 0 silently.
- start while RUN is ignored.
- Branch to the current address (self-loop) is legal and repeats every cycle.

Optional Feature:
- Macro: RET_STACK_EN.
- With the macro:
  - Ports call (in 1), ret (in 1) and stack_err (out 1, sticky, cleared by reset or start) are added.
  - call: redirect as branch and push pc (return address = instr_pc+1).
  - ret: pop and redirect to the popped address.
  - Priority: stall > halt > ret > call > branch_taken.
  - Push when full overwrites the oldest entry (circular) and sets stack_err.
  - Pop when empty: no redirect (sequential fetch) and sets stack_err.
  - Stack pointer is cleared by reset and by start.
- Without the macro: call, ret and stack_err do not exist; behaviour is exactly as above.

Decomposition:
- Package fetch_pkg: state enum (IDLE, RUN, HALTED); ADDR_WIDTH/DATA_WIDTH defaults tied to the `PROG_MEM_* constants from constants.sv.
- Sub-module ret_stack (LIFO of STACK_DEPTH × ADDR_WIDTH with push/pop/full/empty/err), instantiated only under RET_STACK_EN.

Test Plan:
- Reset released, start pulse, ROM model holding word k = k: instr_pc/instr sequence 0,1,2,3 with instr_valid high from the cycle after start; mem_clr=0 after reset.
- Stall held 3 cycles while instr_pc=2: mem_en=0, and instr=2, instr_pc=2 for all 3 cycles; pc=3 resumes afterwards with no instruction lost or duplicated.
- branch_taken with target 0x40 at instr_pc=5: next instr_pc=0x40, then 0x41 (zero bubble). Branch asserted while stall=1: ignored until stall drops.
- halt and branch_taken together at instr_pc=7: state HALTED, instr_valid=0, mem_en=0 next cycle. A later start refetches RESET_VECTOR.
- pc=0xFF with ADDR_WIDTH=8: next instr_pc=0x00. Reset asserted mid-RUN: instr_valid drops and mem_clr rises asynchronously, before the next clock edge.
- RET_STACK_EN: call to 0x20 from 0x10, then ret → instr_pc=0x11. Five nested calls with STACK_DEPTH=4 → stack_err=1. A ret on empty stack → sequential fetch and stack_err=1.
